imem_responder: RTL and testbench
=================================

# imem_responder

Word-addressed instruction memory that answers fetch requests issued by the program counter / fetch logic of the MIPS core. Accepts one 32-bit byte address per valid/ready handshake, inserts a programmable number of wait states, and returns the instruction word (or an error code) on a held response channel. A separate load port writes program words, so benches and boot logic can fill the array without file I/O.

## Interface

- DEPTH, 256: number of 32-bit words; power of two, 4..65536; AW = log2(DEPTH)
- WAIT_STATES, 1: extra cycles between accept and response, 0..7

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address of instruction
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response this cycle
- rsp_instr  out  32  instruction word; 0 when rsp_err != 0
- rsp_err  out  2  bit0 = misaligned (addr[1:0] != 0), bit1 = out of range (addr[31:2] >= DEPTH)
- load_en  in  1  write one word into the array this cycle
- load_addr  in  32  byte address of the word to write
- load_data  in  32  word to write

## Operation

- States: IDLE, WAIT, RESP. req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
- Accept = req_valid && req_ready at a rising edge. At accept: rsp_err computed from req_addr; rsp_instr = mem[req_addr[AW+1:2]] if rsp_err == 0, else 0; wait counter = WAIT_STATES.
- IDLE -> RESP on accept when WAIT_STATES == 0; IDLE -> WAIT on accept otherwise.
- WAIT: counter decrements each edge; WAIT -> RESP on the edge where counter == 1.
- RESP: rsp_instr, rsp_err, rsp_valid held stable until rsp_valid && rsp_ready at an edge; then -> IDLE. No new request accepted in that same edge.
- Out-of-range check covers all of addr[31:2]; high bits above AW+1 nonzero => bit1 set. Both bits may be set together (err = 11).
- Load port: on edge with load_en, mem[load_addr[AW+1:2]] <= load_data, provided load_addr[1:0] == 0 and load_addr[31:2] < DEPTH; otherwise write silently dropped. Load port independent of FSM, legal in any state.
- Read-before-write: accept and load to the same word on the same edge => response carries the old contents. Load after accept never alters an in-flight response.
- Array contents not cleared by reset; preserved across reset.

## Timing

- Reset (reset_n low, asynchronous): state = IDLE, rsp_valid = 0, rsp_instr = 0, rsp_err = 0, counter = 0; req_ready = 0 while reset_n low, 1 from the first cycle after release.
- Reset mid-WAIT or mid-RESP: in-flight fetch discarded, no response emitted.
- Latency: accept at edge T => rsp_valid high from edge T + WAIT_STATES + 1... precisely: visible in the cycle after edge T + WAIT_STATES (W=0: the cycle right after accept).
- Best-case throughput with rsp_ready tied high: one fetch per WAIT_STATES + 2 cycles.
- Backpressure: with rsp_ready low, response held indefinitely, req_ready stays 0.
- All outputs registered except req_ready (decode of state register only; no input-to-output combinational path).

## Test plan

- Reset: assert reset_n low mid-cycle -> rsp_valid/rsp_instr/rsp_err go 0 immediately, req_ready 0; release -> req_ready 1 next cycle.
- WAIT_STATES=0: load 0x20080005 at addr 0x10, request 0x10 with rsp_ready=1 -> rsp_valid the cycle after accept, rsp_instr=0x20080005, rsp_err=00; req_ready back to 1 one cycle later.
- WAIT_STATES=3, rsp_ready=0 for 5 cycles: request 0x0 -> rsp_valid rises 3 cycles after accept cycle's following cycle, instr/err stable through stall, req_ready=0 throughout, clears one edge after rsp_ready=1.
- Errors (DEPTH=256): request 0x6 -> err=01, instr=0; 0x400 -> err=10; 0x402 -> err=11; load to 0x400 dropped (no aliasing into word 0).
- Same-edge hazard: mem[2]=0xAAAA0000, accept 0x8 together with load 0x8 <- 0x55550000 -> response 0xAAAA0000; next fetch of 0x8 -> 0x55550000.
- Reset during WAIT (WAIT_STATES=5): pulse reset_n at cycle 2 of wait -> no rsp_valid ever produced for that request; array word previously loaded still reads back correctly.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory answering fetches after a fixed
// number of wait states, with an independent load port for filling the array.
module imem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [1:0]  rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic        live;
    logic [2:0]  cnt;
    logic [31:0] mem [DEPTH];
    logic        accept;
    logic [1:0]  req_err;
    logic        load_ok;

    // live keeps req_ready low while reset is held and until the first edge after release
    assign req_ready = live && state == IDLE;
    assign accept    = req_valid && req_ready;
    assign req_err   = {|req_addr[31:AW+2], |req_addr[1:0]};
    assign load_ok   = load_en && ~|load_addr[1:0] && ~|load_addr[31:AW+2];

    // Array is deliberately outside the reset domain so program contents survive reset
    always_ff @(posedge clock)
        if (load_ok) mem[load_addr[AW+1:2]] <= load_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            cnt       <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_instr <= 32'h0;
            rsp_err   <= 2'b00;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    rsp_err   <= req_err;
                    rsp_instr <= req_err == 2'b00 ? mem[req_addr[AW+1:2]] : 32'h0;
                    cnt       <= 3'(WAIT_STATES);
                    state     <= WAIT_STATES == 0 ? RESP : WAIT;
                    rsp_valid <= WAIT_STATES == 0;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed scoreboard bench for imem_responder (WAIT_STATES=3 main
// instance plus a WAIT_STATES=0 instance for zero-wait timing).
module tb_imem_responder;
    localparam int W = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, load_en;
    logic [31:0] req_addr, rsp_instr, load_addr, load_data;
    logic [1:0]  rsp_err;

    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_load_en;
    logic [31:0] z_req_addr, z_rsp_instr, z_load_addr, z_load_data;
    logic [1:0]  z_rsp_err;

    int          checks = 0;
    int          miscompares = 0;
    logic [33:0] sb [$];
    logic [31:0] model [256];

    imem_responder #(.DEPTH(256), .WAIT_STATES(W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_instr(z_rsp_instr), .rsp_err(z_rsp_err),
        .load_en(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] expect_of(input logic [31:0] a);
        logic [1:0] e;
        e = {|a[31:10], |a[1:0]};
        return {e, e == 2'b00 ? model[a[9:2]] : 32'h0};
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
        if (a[1:0] == 2'b00 && a[31:10] == 22'h0) model[a[9:2]] = d;
    endtask

    task automatic fetch(input logic [31:0] a, input int stall, input bit hz, input logic [31:0] hd);
        int          lat;
        logic [33:0] held, e;
        @(negedge clock);
        check("req_ready_idle", 34'(req_ready), 34'd1);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
        sb.push_back(expect_of(a));
        if (hz) begin
            load_en = 1'b1; load_addr = a; load_data = hd;
            if (a[1:0] == 2'b00 && a[31:10] == 22'h0) model[a[9:2]] = hd;
        end
        @(negedge clock);
        req_valid = 1'b0; load_en = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 34'(lat), 34'(W + 1));
        held = {rsp_err, rsp_instr};
        for (int i = 0; i < stall; i++) begin
            check("req_ready_stall", 34'(req_ready), 34'd0);
            @(negedge clock);
            check("hold_valid", 34'(rsp_valid), 34'd1);
            check("hold_data", {rsp_err, rsp_instr}, held);
        end
        rsp_ready = 1'b1;
        if (sb.size() == 0) check("sb_empty", 34'd1, 34'd0);
        else begin
            e = sb.pop_front();
            check("rsp", {rsp_err, rsp_instr}, e);
        end
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_valid_clear", 34'(rsp_valid), 34'd0);
        check("req_ready_back", 34'(req_ready), 34'd1);
    endtask

    initial begin
        logic [33:0] e;
        bit          seen;
        reset_n = 1'b0;
        {req_valid, rsp_ready, load_en} = '0;
        {req_addr, load_addr, load_data} = '0;
        {z_req_valid, z_rsp_ready, z_load_en} = '0;
        {z_req_addr, z_load_addr, z_load_data} = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", 34'(req_ready), 34'd0);
        check("rst_out", {rsp_valid, rsp_err, rsp_instr}, 34'd0);
        reset_n = 1'b1;
        #1 check("ready_before_edge", 34'(req_ready), 34'd0);
        @(negedge clock);
        check("ready_after_release", 34'(req_ready), 34'd1);

        // zero wait-state instance: response the cycle after accept
        @(negedge clock);
        z_load_en = 1'b1; z_load_addr = 32'h10; z_load_data = 32'h20080005;
        @(negedge clock);
        z_load_en = 1'b0; z_req_valid = 1'b1; z_req_addr = 32'h10; z_rsp_ready = 1'b1;
        check("w0_ready", 34'(z_req_ready), 34'd1);
        sb.push_back({2'b00, 32'h20080005});
        @(negedge clock);
        z_req_valid = 1'b0;
        check("w0_valid", 34'(z_rsp_valid), 34'd1);
        check("w0_ready_busy", 34'(z_req_ready), 34'd0);
        e = sb.pop_front();
        check("w0_rsp", {z_rsp_err, z_rsp_instr}, e);
        @(negedge clock);
        z_rsp_ready = 1'b0;
        check("w0_valid_clear", 34'(z_rsp_valid), 34'd0);
        check("w0_ready_back", 34'(z_req_ready), 34'd1);

        load(32'h0, 32'h11111111);
        load(32'h4, 32'h22222222);
        load(32'h8, 32'hAAAA0000);
        load(32'h10, 32'h20080005);
        load(32'h3FC, 32'hCAFEF00D);
        fetch(32'h0, 5, 1'b0, 32'h0);
        fetch(32'h10, 0, 1'b0, 32'h0);
        fetch(32'h3FC, 1, 1'b0, 32'h0);
        fetch(32'h6, 0, 1'b0, 32'h0);
        fetch(32'h400, 0, 1'b0, 32'h0);
        fetch(32'h402, 2, 1'b0, 32'h0);
        fetch(32'h80000010, 0, 1'b0, 32'h0);
        load(32'h400, 32'hDEADBEEF);
        load(32'h5, 32'hBADBAD00);
        fetch(32'h0, 0, 1'b0, 32'h0);
        fetch(32'h4, 0, 1'b0, 32'h0);
        fetch(32'h8, 1, 1'b1, 32'h55550000);
        fetch(32'h8, 0, 1'b0, 32'h0);

        // asynchronous reset while a response is held
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h4;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (W) @(negedge clock);
        check("pre_reset_valid", 34'(rsp_valid), 34'd1);
        #2 reset_n = 1'b0;
        #1 check("async_rst_out", {rsp_valid, rsp_err, rsp_instr}, 34'd0);
        check("async_rst_ready", 34'(req_ready), 34'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_rst2", 34'(req_ready), 34'd1);

        // reset in the middle of the wait period discards the fetch
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_wait_reset", 34'(seen), 34'd0);
        fetch(32'h10, 0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end
endmodule
